// File: rtl/ifu_prefetch_pkg.sv
// Shared fetch-side constants: reset PC, instruction size and the bubble encoding.
package ifu_prefetch_pkg;

   localparam logic [31:0] PC_START_DEF = 32'h0000_3000;
   localparam int          INSTR_BYTES  = 4;
   localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;

   function automatic int cnt_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/ifu_prefetch_if.sv
// Handshake bundle between the prefetch unit, instruction memory, redirect source and decode.
interface ifu_prefetch_if #(parameter int XLEN = 32);

   logic            imem_req_valid;
   logic            imem_req_ready;
   logic [XLEN-1:0] imem_req_addr;
   logic            imem_rsp_valid;
   logic [XLEN-1:0] imem_rsp_data;
   logic            redirect_valid;
   logic [XLEN-1:0] redirect_pc;
   logic            if_valid;
   logic            if_ready;
   logic [XLEN-1:0] if_pc;
   logic [XLEN-1:0] if_pc4;
   logic [XLEN-1:0] if_instr;

   modport master (
      output imem_req_valid, imem_req_addr, if_valid, if_pc, if_pc4, if_instr,
      input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, if_ready
   );

   modport slave (
      input  imem_req_valid, imem_req_addr, if_valid, if_pc, if_pc4, if_instr,
      output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, if_ready
   );

endinterface

// File: rtl/ifu_prefetch_fetch_queue.sv
// Circular FIFO with an extra pointer bit for full/empty; flush wins over push and pop.
module fetch_queue import ifu_prefetch_pkg::*; #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   push,
   input  logic                   pop,
   input  logic                   flush,
   input  logic [WIDTH-1:0]       wdata,
   output logic [WIDTH-1:0]       rdata,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wptr, rptr;
   logic             do_push, do_pop;

   assign count   = wptr - rptr;
   assign empty   = (wptr == rptr);
   assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
   assign do_pop  = pop && !empty && !flush;
   // A push into a full queue is only legal when the head leaves in the same cycle.
   assign do_push = push && !flush && (!full || do_pop);
   assign rdata   = mem[rptr[AW-1:0]];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wptr <= '0;
         rptr <= '0;
      end else if (flush) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (do_push) wptr <= wptr + (AW+1)'(1);
         if (do_pop)  rptr <= rptr + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wptr[AW-1:0]] <= wdata;
   end

   always_ff @(posedge clk) begin
      if (reset_n) assert (!(push && full && !pop && !flush));
   end

endmodule

// File: rtl/ifu_prefetch.sv
// Decoupled instruction fetch: credit-limited request issue, in-order response queue, redirect flush.
module ifu_prefetch import ifu_prefetch_pkg::*; #(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] PC_START = XLEN'(PC_START_DEF),
   parameter int              DEPTH    = 4
) (
   input  logic            clk,
   input  logic            reset_n,
   ifu_prefetch_if.master  bus
);

   localparam int CW = cnt_w(DEPTH);

   logic [XLEN-1:0]   fpc, tag_pc;
   logic [CW-1:0]     outstanding, drop, occ;
   logic [2*XLEN-1:0] head;
   logic              q_full, q_empty;
   logic              credit_ok, req_fire, push, pop, redirect;
   logic [XLEN-1:0]   head_pc;
   logic              unused_ok;

   assign redirect  = bus.redirect_valid;
   assign credit_ok = ({1'b0, occ} + {1'b0, outstanding}) < (CW+1)'(DEPTH);
   assign bus.imem_req_valid = reset_n && credit_ok && !redirect;
   assign bus.imem_req_addr  = fpc;
   assign req_fire = bus.imem_req_valid && bus.imem_req_ready;
   assign push     = bus.imem_rsp_valid && (drop == '0);
   assign pop      = bus.if_valid && bus.if_ready;

   fetch_queue #(.WIDTH(2*XLEN), .DEPTH(DEPTH)) u_queue (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (push),
      .pop     (pop),
      .flush   (redirect),
      .wdata   ({tag_pc, bus.imem_rsp_data}),
      .rdata   (head),
      .full    (q_full),
      .empty   (q_empty),
      .count   (occ)
   );

   assign head_pc      = head[2*XLEN-1:XLEN];
   assign bus.if_valid = !q_empty;
   assign bus.if_pc    = bus.if_valid ? head_pc : '0;
   assign bus.if_instr = bus.if_valid ? head[XLEN-1:0] : '0;
   assign bus.if_pc4   = bus.if_valid ? head_pc + XLEN'(INSTR_BYTES) : '0;
   assign unused_ok    = &{1'b0, bus.redirect_pc[1:0], q_full};

   // outstanding counts every in-flight response, including the doomed ones tracked by drop.
   // tag_pc is the address of the oldest in-flight request that will actually be kept.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         fpc         <= PC_START;
         tag_pc      <= PC_START;
         outstanding <= '0;
         drop        <= '0;
      end else begin
         outstanding <= outstanding + CW'(req_fire) - CW'(bus.imem_rsp_valid);
         if (redirect) begin
            fpc    <= {bus.redirect_pc[XLEN-1:2], 2'b00};
            tag_pc <= {bus.redirect_pc[XLEN-1:2], 2'b00};
            drop   <= outstanding - CW'(bus.imem_rsp_valid);
         end else begin
            if (req_fire) fpc <= fpc + XLEN'(INSTR_BYTES);
            if (bus.imem_rsp_valid) begin
               if (drop != '0) drop   <= drop - CW'(1);
               else            tag_pc <= tag_pc + XLEN'(INSTR_BYTES);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset_n) begin
         assert (!(bus.imem_rsp_valid && outstanding == '0));
         assert (!bus.imem_req_valid || bus.imem_req_addr[1:0] == 2'b00);
      end
   end

endmodule

// File: tb/tb_ifu_prefetch.sv
// Randomised bench for ifu_prefetch: memory model with configurable latency and an in-order stream model.
module tb_ifu_prefetch;

   localparam int DEPTH = 4;

   logic clk = 1'b0;
   logic reset_n = 1'b0;

   ifu_prefetch_if #(.XLEN(32)) ifc ();

   ifu_prefetch #(.XLEN(32), .PC_START(32'h0000_3000), .DEPTH(DEPTH)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (ifc.master)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      int          due;
   } req_t;

   req_t        infl[$];
   int          nvec = 0, nerr = 0, cyc = 0, lat = 1, accepts = 0, pops = 0;
   bit          rdy = 1'b1, ifr = 1'b1, redir = 1'b0;
   logic [31:0] redir_pc = '0;
   logic [31:0] exp_pc = 32'h3000, exp_fpc = 32'h3000;
   bit          s_ifv, s_rsp, s_reqv;
   logic [31:0] s_pc;

   // One clock: drive at negedge, sample just before posedge, advance the stream model after it.
   task automatic cycle();
      bit acc, pop, rsp;
      logic [31:0] a;
      @(negedge clk);
      rsp = (infl.size() != 0) && (infl[0].due <= cyc);
      ifc.imem_rsp_valid = rsp;
      ifc.imem_rsp_data  = rsp ? (infl[0].addr ^ 32'hFFFF_FFFF) : 32'h0;
      ifc.imem_req_ready = rdy;
      ifc.if_ready       = ifr;
      ifc.redirect_valid = redir;
      ifc.redirect_pc    = redir_pc;
      #4;
      s_ifv  = ifc.if_valid;
      s_rsp  = rsp;
      s_reqv = ifc.imem_req_valid;
      s_pc   = ifc.if_pc;
      acc = ifc.imem_req_valid && rdy;
      pop = ifc.if_valid && ifr && !redir;
      a   = ifc.imem_req_addr;
      if (redir) begin
         nvec++;
         if (ifc.imem_req_valid !== 1'b0) begin
            nerr++;
            $display("FAIL req_on_redirect: imem_req_valid=%b want 0 (cyc %0d)", ifc.imem_req_valid, cyc);
         end
      end
      if (acc) begin
         nvec++;
         if (a !== exp_fpc) begin
            nerr++;
            $display("FAIL req_addr: got %h want %h (cyc %0d)", a, exp_fpc, cyc);
         end
      end
      if (pop) begin
         nvec++;
         if (ifc.if_pc !== exp_pc || ifc.if_instr !== (exp_pc ^ 32'hFFFF_FFFF) ||
             ifc.if_pc4 !== exp_pc + 32'd4) begin
            nerr++;
            $display("FAIL decode_pair: got pc=%h instr=%h pc4=%h want pc=%h instr=%h pc4=%h (cyc %0d)",
                     ifc.if_pc, ifc.if_instr, ifc.if_pc4, exp_pc, exp_pc ^ 32'hFFFF_FFFF,
                     exp_pc + 32'd4, cyc);
         end
      end
      @(posedge clk);
      #1;
      if (rsp) void'(infl.pop_front());
      if (acc) begin
         infl.push_back('{a, cyc + lat});
         accepts++;
      end
      nvec++;
      if (infl.size() > DEPTH) begin
         nerr++;
         $display("FAIL credit: in-flight %0d want <= %0d (cyc %0d)", infl.size(), DEPTH, cyc);
      end
      if (redir) begin
         exp_pc  = redir_pc & ~32'h3;
         exp_fpc = redir_pc & ~32'h3;
      end else begin
         if (pop) begin
            exp_pc += 32'd4;
            pops++;
         end
         if (acc) exp_fpc += 32'd4;
      end
      cyc++;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset_n = 1'b0;
      rdy = 1'b1; ifr = 1'b1; redir = 1'b0; redir_pc = '0;
      ifc.imem_rsp_valid = 1'b0; ifc.imem_rsp_data = '0; ifc.imem_req_ready = 1'b1;
      ifc.if_ready = 1'b1; ifc.redirect_valid = 1'b0; ifc.redirect_pc = '0;
      infl.delete();
      exp_pc = 32'h3000; exp_fpc = 32'h3000;
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
   endtask

   task automatic test_reset();
      ifc.imem_rsp_valid = 1'b0; ifc.imem_rsp_data = '0; ifc.imem_req_ready = 1'b1;
      ifc.if_ready = 1'b1; ifc.redirect_valid = 1'b0; ifc.redirect_pc = '0;
      for (int k = 0; k < 2; k++) begin
         if (k == 0) begin @(negedge clk); #1; end
         else        begin @(posedge clk); #1; end
         nvec += 3;
         if (ifc.imem_req_valid !== 1'b0 || ifc.if_valid !== 1'b0) begin
            nerr++;
            $display("FAIL reset_valids: req_valid=%b if_valid=%b want 0 0", ifc.imem_req_valid, ifc.if_valid);
         end
         if (ifc.if_pc !== 32'h0 || ifc.if_pc4 !== 32'h0) begin
            nerr++;
            $display("FAIL reset_pc: if_pc=%h if_pc4=%h want 0 0", ifc.if_pc, ifc.if_pc4);
         end
         if (ifc.if_instr !== 32'h0) begin
            nerr++;
            $display("FAIL reset_instr: got %h want 0", ifc.if_instr);
         end
      end
   endtask

   task automatic test_stream();
      bit seen [3];
      int p0;
      do_reset();
      lat = 1;
      for (int k = 0; k < 3; k++) begin
         cycle();
         seen[k] = s_ifv;
      end
      nvec++;
      if (seen[0] !== 1'b0 || seen[1] !== 1'b0 || seen[2] !== 1'b1 || s_pc !== 32'h3000) begin
         nerr++;
         $display("FAIL first_latency: if_valid seq %b%b%b pc=%h want 001 pc=00003000",
                  seen[0], seen[1], seen[2], s_pc);
      end
      p0 = pops;
      repeat (20) cycle();
      nvec++;
      if (pops - p0 != 20) begin
         nerr++;
         $display("FAIL throughput: got %0d pops want 20", pops - p0);
      end
   endtask

   task automatic test_stall();
      int a0, p0;
      do_reset();
      lat = 1; ifr = 1'b0;
      a0 = accepts;
      repeat (10) cycle();
      nvec += 2;
      if (accepts - a0 != DEPTH || s_reqv !== 1'b0) begin
         nerr++;
         $display("FAIL stall_credit: accepts=%0d req_valid=%b want %0d 0", accepts - a0, s_reqv, DEPTH);
      end
      if (s_ifv !== 1'b1 || s_pc !== 32'h3000) begin
         nerr++;
         $display("FAIL stall_head: if_valid=%b pc=%h want 1 00003000", s_ifv, s_pc);
      end
      ifr = 1'b1;
      p0 = pops;
      repeat (8) cycle();
      nvec++;
      if (pops - p0 != 8) begin
         nerr++;
         $display("FAIL stall_drain: got %0d pops want 8", pops - p0);
      end
   endtask

   task automatic test_redirect_drop();
      bit got;
      do_reset();
      lat = 3;
      repeat (2) cycle();
      nvec++;
      if (infl.size() != 2) begin
         nerr++;
         $display("FAIL redir_setup: in-flight %0d want 2", infl.size());
      end
      redir = 1'b1; redir_pc = 32'h0000_3401;
      cycle();
      redir = 1'b0;
      got = 1'b0;
      for (int k = 0; k < 20 && !got; k++) begin
         cycle();
         got = s_ifv;
      end
      nvec++;
      if (!got || s_pc !== 32'h3400) begin
         nerr++;
         $display("FAIL redir_first_pc: valid=%b pc=%h want 1 00003400", got, s_pc);
      end
      repeat (10) cycle();
   endtask

   task automatic test_back_to_back_redirect();
      bit got;
      int p0;
      do_reset();
      lat = 2;
      repeat (8) cycle();
      redir = 1'b1;
      redir_pc = 32'h0000_5000 | ($urandom & 32'h0000_0FFF);
      cycle();
      nvec++;
      if (s_rsp !== 1'b1 || s_ifv !== 1'b1) begin
         nerr++;
         $display("FAIL combo_setup: rsp=%b if_valid=%b want 1 1", s_rsp, s_ifv);
      end
      redir_pc = 32'h0000_3800;
      cycle();
      redir = 1'b0;
      got = 1'b0;
      for (int k = 0; k < 20 && !got; k++) begin
         cycle();
         got = s_ifv;
      end
      nvec++;
      if (!got || s_pc !== 32'h3800) begin
         nerr++;
         $display("FAIL b2b_first_pc: valid=%b pc=%h want 1 00003800", got, s_pc);
      end
      p0 = pops;
      repeat (12) cycle();
      nvec++;
      if (pops - p0 != 12) begin
         nerr++;
         $display("FAIL b2b_resume: got %0d pops want 12", pops - p0);
      end
   endtask

   task automatic test_random();
      bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
      int p0;
      do_reset();
      p0 = pops;
      for (int i = 0; i < 400; i++) begin
         rdy = pat[i % 4];
         ifr = 1'($urandom_range(0, 1));
         lat = 1 + (i / 100) % 3;
         redir = (i == 200) || (i > 215 && $urandom_range(0, 24) == 0);
         redir_pc = (i == 200) ? 32'hFFFF_FFF9 : ($urandom & 32'h000F_FFFF);
         cycle();
      end
      redir = 1'b0; ifr = 1'b1; rdy = 1'b1;
      repeat (30) cycle();
      nvec++;
      if (pops - p0 < 40) begin
         nerr++;
         $display("FAIL random_progress: got %0d pops want >= 40", pops - p0);
      end
   endtask

   task automatic test_async_reset();
      bit got;
      do_reset();
      lat = 2; ifr = 1'b0;
      repeat (4) cycle();
      @(negedge clk);
      #3;
      nvec++;
      if (ifc.if_valid !== 1'b1 || infl.size() != 2) begin
         nerr++;
         $display("FAIL areset_pre: if_valid=%b in-flight=%0d want 1 2", ifc.if_valid, infl.size());
      end
      reset_n = 1'b0;
      #1;
      nvec++;
      if (ifc.if_valid !== 1'b0 || ifc.imem_req_valid !== 1'b0 || ifc.if_pc !== 32'h0 ||
          ifc.if_instr !== 32'h0 || ifc.if_pc4 !== 32'h0) begin
         nerr++;
         $display("FAIL areset_clear: if_valid=%b req_valid=%b pc=%h instr=%h pc4=%h want all 0",
                  ifc.if_valid, ifc.imem_req_valid, ifc.if_pc, ifc.if_instr, ifc.if_pc4);
      end
      do_reset();
      lat = 1;
      got = 1'b0;
      for (int k = 0; k < 10 && !got; k++) begin
         cycle();
         got = s_ifv;
      end
      nvec++;
      if (!got || s_pc !== 32'h3000) begin
         nerr++;
         $display("FAIL areset_restart: valid=%b pc=%h want 1 00003000", got, s_pc);
      end
      repeat (6) cycle();
   endtask

   initial begin
      test_reset();
      test_stream();
      test_stall();
      test_redirect_drop();
      test_back_to_back_redirect();
      test_random();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

endmodule
